decoder_scan_ctrl: RTL and testbench
====================================

# decoder_scan_ctrl

Scan sequencer that drives the select and enable inputs of the 3-to-8 decoder (`decoder_3`): g1, g2a, g2b, c, b, a. It steps through the enabled channels of an 8-bit mask and holds each selected channel active for a fixed dwell time. A blanking interval with the decoder disabled separates consecutive channels. Typical use is time-multiplexed scanning of an 8-digit display or LED column array.

## Interface
- DWELL, 16: cycles the decoder stays enabled per channel; legal range ≥1.
- BLANK, 2: cycles the decoder stays disabled before each channel; legal range ≥1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run request.
- mask  input  8  channel enables; bit i set means channel i is scanned.
- g1  output  1  decoder enable, active high.
- g2a  output  1  decoder enable, active low.
- g2b  output  1  decoder enable, active low; always equal to g2a.
- c, b, a  output  1 each  channel select; c is MSB.
- frame_done  output  1  one-cycle pulse marking completion of a full pass over the enabled channels.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Design is one clock domain with asynchronous active-low reset. All outputs are registered.
- Reset values (asynchronous):
  - state = IDLE, {c,b,a} = 3'b000, g1 = 0, g2a = g2b = 1.
  - frame_done = 0, busy = 0, dwell/blank counter = 0.
- "Decoder off" means g1 = 0 and g2a = g2b = 1. "Decoder on" means g1 = 1 and g2a = g2b = 0.
- Down-counter width is $clog2(max(DWELL,BLANK)+1).
- States:
  - IDLE: decoder off. If en = 1 and mask != 0, load {c,b,a} with the lowest set bit index of mask, load the counter with BLANK-1, and go to BLNK.
  - BLNK: decoder off. If en = 0, go to IDLE next cycle and keep {c,b,a}. Otherwise decrement the counter. When the counter reaches 0, load DWELL-1 and go to ACT.
  - ACT: decoder on. Decrement the counter. en is ignored until the dwell completes. When the counter reaches 0, take the terminal action below.
- Terminal action at the end of ACT:
  - If en = 0 or mask = 0, go to IDLE.
  - Otherwise select the next set mask bit strictly above the current index, wrapping past 7 to the lowest set bit. Load BLANK-1 and go to BLNK.
  - If that search wrapped (new index ≤ old index), assert frame_done in the first BLNK cycle.
  - With exactly one bit set, the next channel is the same channel and frame_done fires every pass.
- mask is sampled only at IDLE exit and at ACT termination. Changes at any other time have no effect until then.
- {c,b,a} changes only on the edge that enters BLNK from ACT, or on IDLE exit. The select is therefore stable the whole time g1 = 1.
- No illegal states: any unused state encoding returns to IDLE on the next edge.

## Timing
- After en rises (sampled at edge N), busy = 1 and the state is BLNK from edge N.
- g1 rises at edge N+BLANK.
- g1 stays high for exactly DWELL cycles, then is low for exactly BLANK cycles before the next channel.
- Channel period is BLANK+DWELL cycles. Frame period with k enabled channels is k·(BLANK+DWELL) cycles.
- frame_done is high for 1 cycle, coincident with the first BLNK cycle of the new frame. The first pass after IDLE produces no leading pulse.
- Dropping en:
  - in BLNK: IDLE after 1 edge;
  - in ACT: the remaining dwell completes, then IDLE. No frame_done is issued on this exit.
- rst_n asserted mid-ACT forces the decoder off immediately (asynchronously), not at the next edge.

## Test plan
- Reset asserted mid-ACT at channel 5 -> g1 = 0, g2a = g2b = 1, {c,b,a} = 0, busy = 0 without waiting for a clock edge; scanning restarts from channel 0 after release with en = 1.
- DWELL = 4, BLANK = 2, mask = 8'hFF, en = 1 -> {c,b,a} steps 0..7, each with g1 high for 4 cycles and low for 2; frame_done pulses every 48 cycles, at the BLNK following channel 7.
- mask = 8'b1010_0100 -> channel order 2, 5, 7, 2, ...; frame_done pulses after channel 7; period 18 cycles.
- mask = 8'h08 -> {c,b,a} stays 3'b011; frame_done pulses every 6 cycles; g1 pattern low 2 / high 4.
- en dropped at the 2nd ACT cycle of channel 3 -> g1 stays high 2 more cycles, then IDLE with {c,b,a} = 3 and no frame_done. en dropped in BLNK -> IDLE on the next edge.
- en = 1 with mask = 0 -> remains IDLE, busy = 0. mask changed from 8'hFF to 8'h01 mid-dwell of channel 2 -> channel 2 completes, next channel is 0, and frame_done fires.

Source files
------------

// File: rtl/decoder_scan_if.sv
// decoder_scan_if: run request, channel mask and decoder drive bundle
interface decoder_scan_if;
  logic       en;
  logic [7:0] mask;
  logic       g1;
  logic       g2a;
  logic       g2b;
  logic       c;
  logic       b;
  logic       a;
  logic       frame_done;
  logic       busy;
  modport master (output en, mask, input g1, g2a, g2b, c, b, a, frame_done, busy);
  modport slave (input en, mask, output g1, g2a, g2b, c, b, a, frame_done, busy);
endinterface

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scans enabled mask channels through a 3-to-8 decoder with dwell and blanking
module decoder_scan_ctrl #(
  parameter int DWELL = 16,
  parameter int BLANK = 2
) (
  input logic          clk,
  input logic          rst_n,
  decoder_scan_if.slave bus
);
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, BLNK, ACT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] sel, sel_nx, nxt, first;
  logic fd_nx, g1_q, busy_q, fd_q;
  // next set bit strictly above from, wrapping; from itself has lowest priority
  function automatic logic [2:0] pick(input logic [7:0] m, input logic [2:0] from);
    logic [2:0] j;
    pick = from;
    for (int i = 8; i >= 1; i--) begin
      j = from + 3'(i);
      if (m[j]) pick = j;
    end
  endfunction
  assign nxt   = pick(bus.mask, sel);
  assign first = pick(bus.mask, 3'd7);
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    fd_nx    = 1'b0;
    case (state)
      IDLE: if (bus.en && |bus.mask) begin
        sel_nx   = first;
        cnt_nx   = CW'(BLANK - 1);
        state_nx = BLNK;
      end
      BLNK: if (!bus.en) state_nx = IDLE;
        else if (cnt == '0) begin
          cnt_nx   = CW'(DWELL - 1);
          state_nx = ACT;
        end else cnt_nx = cnt - CW'(1);
      ACT: if (cnt != '0) cnt_nx = cnt - CW'(1);
        else if (!bus.en || bus.mask == '0) state_nx = IDLE;
        else begin
          sel_nx   = nxt;
          cnt_nx   = CW'(BLANK - 1);
          state_nx = BLNK;
          fd_nx    = nxt <= sel;
        end
      default: state_nx = IDLE;
    endcase
  end
  // outputs are registered from next-state so they align with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= '0;
      g1_q   <= 1'b0;
      busy_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sel    <= sel_nx;
      g1_q   <= state_nx == ACT;
      busy_q <= state_nx != IDLE;
      fd_q   <= fd_nx;
    end
  end
  assign bus.g1 = g1_q;
  assign bus.g2a = ~g1_q;
  assign bus.g2b = ~g1_q;
  assign {bus.c, bus.b, bus.a} = sel;
  assign bus.frame_done = fd_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed checks of scan order, timing, en drop, mask change and async reset
module tb_decoder_scan_ctrl;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int PER = DW + BL;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] ov;
  decoder_scan_if bus();
  decoder_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign ov = {bus.g1, bus.g2a, bus.g2b, bus.c, bus.b, bus.a, bus.frame_done, bus.busy};
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] vec(input logic g1, input logic [2:0] ch, input logic fd, input logic busy);
    return {g1, ~g1, ~g1, ch, fd, busy};
  endfunction
  task automatic run_scan(input string tag, input logic [7:0] m, input int n);
    int ch[$];
    int k;
    for (int i = 0; i < 8; i++) if (m[i]) ch.push_back(i);
    k = ch.size();
    bus.en = 1'b1;
    bus.mask = m;
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      check(tag, ov, vec((t % PER) >= BL, 3'(ch[(t / PER) % k]), t > 0 && t % (PER * k) == 0, 1'b1));
      @(negedge clk);
    end
  endtask
  task automatic stop_idle(input string tag);
    int n = 0;
    bus.en = 1'b0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {bus.busy, bus.g1, bus.frame_done}, 3'b000);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.en = 1'b0;
    bus.mask = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_state", ov, vec(1'b0, 3'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", ov, vec(1'b0, 3'd0, 1'b0, 1'b0));
    run_scan("scan_ff", 8'hFF, 100);
    stop_idle("stop_ff");
    run_scan("scan_a4", 8'b1010_0100, 40);
    stop_idle("stop_a4");
    run_scan("scan_08", 8'h08, 20);
    stop_idle("stop_08");
    run_scan("pre_drop_act", 8'hFF, 21);
    bus.en = 1'b0;
    check("drop_act_t21", ov, vec(1'b1, 3'd3, 1'b0, 1'b1));
    @(negedge clk);
    check("drop_act_t22", ov, vec(1'b1, 3'd3, 1'b0, 1'b1));
    @(negedge clk);
    check("drop_act_t23", ov, vec(1'b1, 3'd3, 1'b0, 1'b1));
    @(negedge clk);
    check("drop_act_idle", ov, vec(1'b0, 3'd3, 1'b0, 1'b0));
    @(negedge clk);
    check("drop_act_stay", ov, vec(1'b0, 3'd3, 1'b0, 1'b0));
    run_scan("pre_drop_blnk", 8'hFF, 6);
    bus.en = 1'b0;
    @(negedge clk);
    check("drop_blnk_idle", ov, vec(1'b0, 3'd1, 1'b0, 1'b0));
    bus.en = 1'b1;
    bus.mask = 8'h00;
    repeat (5) @(negedge clk);
    check("mask_zero_idle", ov, vec(1'b0, 3'd1, 1'b0, 1'b0));
    run_scan("pre_mask_chg", 8'hFF, 15);
    bus.mask = 8'h01;
    check("mask_chg_t15", ov, vec(1'b1, 3'd2, 1'b0, 1'b1));
    @(negedge clk);
    check("mask_chg_t16", ov, vec(1'b1, 3'd2, 1'b0, 1'b1));
    @(negedge clk);
    check("mask_chg_t17", ov, vec(1'b1, 3'd2, 1'b0, 1'b1));
    @(negedge clk);
    check("mask_chg_wrap", ov, vec(1'b0, 3'd0, 1'b1, 1'b1));
    @(negedge clk);
    check("mask_chg_t19", ov, vec(1'b0, 3'd0, 1'b0, 1'b1));
    @(negedge clk);
    check("mask_chg_act0", ov, vec(1'b1, 3'd0, 1'b0, 1'b1));
    stop_idle("stop_mask_chg");
    run_scan("pre_reset", 8'hFF, 32);
    check("act_ch5", ov, vec(1'b1, 3'd5, 1'b0, 1'b1));
    #2 rst_n = 1'b0;
    #1 check("async_reset", ov, vec(1'b0, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("restart", 8'hFF, 8);
    stop_idle("stop_restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
